output_vc_scheduler: RTL

OUTPUT_VC_SCHEDULER -- requirements
Module: output_vc_scheduler

---
 rtl/noc_pkg.sv | 20 ++
 rtl/rr_pick4.sv | 26 ++
 rtl/output_vc_scheduler.sv | 84 ++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC constants: packet geometry, VC encoding and pointer helpers.
package noc_pkg;

  localparam int unsigned NOC_DATA_W = 64;
  localparam int unsigned NOC_N_REQ  = 4;
  localparam int unsigned NOC_VC_BIT = 63;
  localparam int unsigned PTR_W      = 2;

  // Virtual-channel tag carried in the packet VC bit.
  typedef enum logic {
    VC_EVEN = 1'b0,
    VC_ODD  = 1'b1
  } vc_e;

  // Round-robin pointer value following a grant to index g (wraps 3 -> 0).
  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] g);
    return g + PTR_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Four-way rotating-priority picker: first eligible index at or above ptr, mod 4.
module rr_pick4
  import noc_pkg::*;
(
  input  logic [3:0]       eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [3:0]       grant,
  output logic             valid
);

  // Walk the four candidates starting at the pointer; take the first eligible one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    grant = 4'b0000;
    valid = 1'b0;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + PTR_W'(k);
      if (!valid && eligible[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_vc_scheduler.sv
// Output-port scheduler: alternates even/odd VC every cycle and grants one
// requester per cycle round-robin within the serviced VC.
module output_vc_scheduler
  import noc_pkg::*;
#(
  parameter int unsigned DATA_W = NOC_DATA_W,
  parameter int unsigned N_REQ  = NOC_N_REQ,
  parameter int unsigned VC_BIT = NOC_VC_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] pkt0,
  input  logic [DATA_W-1:0] pkt1,
  input  logic [DATA_W-1:0] pkt2,
  input  logic [DATA_W-1:0] pkt3,
  input  logic              fifo_full,
  output logic [N_REQ-1:0]  grant,
  output logic [DATA_W-1:0] out_packet,
  output logic              wr_en,
  output logic              polarity
);

  logic [PTR_W-1:0]  ptr_even;
  logic [PTR_W-1:0]  ptr_odd;
  logic [PTR_W-1:0]  active_ptr;
  logic [3:0]        vc_match;
  logic [3:0]        eligible;
  logic [3:0]        pick;
  logic              pick_valid;
  logic [PTR_W-1:0]  pick_idx;
  logic [DATA_W-1:0] pick_pkt;

  // Eligibility: valid head, VC matches the serviced VC, room downstream, not in reset.
  always_comb begin
    vc_match[0] = (pkt0[VC_BIT] == polarity);
    vc_match[1] = (pkt1[VC_BIT] == polarity);
    vc_match[2] = (pkt2[VC_BIT] == polarity);
    vc_match[3] = (pkt3[VC_BIT] == polarity);
    eligible    = (reset || fifo_full) ? 4'b0000 : (req & vc_match);
    active_ptr  = (polarity == VC_ODD) ? ptr_odd : ptr_even;
  end

  rr_pick4 u_pick (
    .eligible (eligible),
    .ptr      (active_ptr),
    .grant    (pick),
    .valid    (pick_valid)
  );

  assign grant = pick;

  // Encode the one-hot pick to an index and select the granted packet.
  always_comb begin
    pick_idx = '0;
    pick_pkt = pkt0;
    unique case (pick)
      4'b0010: begin pick_idx = PTR_W'(1); pick_pkt = pkt1; end
      4'b0100: begin pick_idx = PTR_W'(2); pick_pkt = pkt2; end
      4'b1000: begin pick_idx = PTR_W'(3); pick_pkt = pkt3; end
      default: begin pick_idx = '0;        pick_pkt = pkt0; end
    endcase
  end

  // All scheduler state: VC polarity, both RR pointers, registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      polarity   <= 1'b0;
      ptr_even   <= '0;
      ptr_odd    <= '0;
      wr_en      <= 1'b0;
      out_packet <= '0;
    end else begin
      polarity <= ~polarity;
      wr_en    <= pick_valid;
      if (pick_valid) begin
        out_packet <= pick_pkt;
        if (polarity == VC_ODD) ptr_odd  <= ptr_after(pick_idx);
        else                    ptr_even <= ptr_after(pick_idx);
      end
    end
  end

endmodule
